// File: rtl/allbit_or_32bit.sv
// ---------------------------------------------------------------------------
// allbit_or_32bit
//   32-bit OR reduction. The divider uses it to detect a nonzero divisor.
//
//   Ports:
//     i_data  in  [31:0]  word to reduce
//     o_any   out         1 when any bit of i_data is set
// ---------------------------------------------------------------------------
module allbit_or_32bit (
    input  logic [31:0] i_data,
    output logic        o_any
);

    assign o_any = |i_data;

endmodule

// File: rtl/div_32bit_seq.sv
// ---------------------------------------------------------------------------
// div_32bit_seq
//   Sequential signed 32-bit divider for the multdiv unit. It computes the
//   quotient data_operandA / data_operandB using restoring division on the
//   operand magnitudes, one iteration per clock. The quotient truncates
//   toward zero, and the sign is applied when the result is registered.
//
//   Ports:
//     clock           in        rising-edge clock
//     reset           in        asynchronous, active-high reset
//     ctrl_DIV        in        start pulse; operands are sampled on the same edge
//     data_operandA   in  [31:0] dividend, two's complement
//     data_operandB   in  [31:0] divisor, two's complement
//     data_result     out [31:0] quotient; held until the next result
//     data_exception  out        divide-by-zero, valid while data_resultRDY=1
//     data_resultRDY  out        one-cycle ready pulse
//
//   Valid/ready: there is no backpressure. A start is accepted on any edge
//   where ctrl_DIV=1, including during RUN (which aborts the current
//   operation) and DONE (the pulse for the finished operation is still
//   shown). data_resultRDY is high for exactly one cycle per completed
//   operation, and data_result/data_exception are meaningful in that cycle.
// ---------------------------------------------------------------------------
module div_32bit_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
);

    localparam logic [1:0]       S_IDLE    = 2'd0;
    localparam logic [1:0]       S_RUN     = 2'd1;
    localparam logic [1:0]       S_DONE    = 2'd2;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;     // holds |A| at start, shifts out as quotient bits shift in
    logic [WIDTH-1:0] r_div;     // |B|
    logic             r_sign;
    logic [WIDTH-1:0] r_result;
    logic             r_exc;
    logic             r_rdy;

    logic             w_b_nonzero;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic [WIDTH-1:0] w_rem_sh;
    logic [WIDTH:0]   w_trial;
    logic             w_fits;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_quo_next;

    allbit_or_32bit u_b_or (
        .i_data (data_operandB),
        .o_any  (w_b_nonzero)
    );

    // Magnitudes. The magnitude of 0x80000000 is 0x80000000, read as unsigned.
    assign w_abs_a = data_operandA[WIDTH-1] ? (~data_operandA + ONE) : data_operandA;
    assign w_abs_b = data_operandB[WIDTH-1] ? (~data_operandB + ONE) : data_operandB;

    // One restoring step. The shift moves {rem, quo} left by one bit, and a
    // 33-bit subtract is used so that its top bit acts as the borrow (negative) flag.
    assign w_rem_sh   = {r_rem[WIDTH-2:0], r_quo[WIDTH-1]};
    assign w_trial    = {1'b0, w_rem_sh} - {1'b0, r_div};
    assign w_fits     = ~w_trial[WIDTH];
    assign w_rem_next = w_fits ? w_trial[WIDTH-1:0] : w_rem_sh;
    assign w_quo_next = {r_quo[WIDTH-2:0], w_fits};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_div    <= '0;
            r_sign   <= 1'b0;
            r_result <= '0;
            r_exc    <= 1'b0;
            r_rdy    <= 1'b0;
        end else if (ctrl_DIV) begin
            r_quo  <= w_abs_a;
            r_div  <= w_abs_b;
            r_sign <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            r_rem  <= '0;
            r_cnt  <= '0;
            if (!w_b_nonzero) begin
                r_state  <= S_DONE;
                r_result <= '0;
                r_exc    <= 1'b1;
                r_rdy    <= 1'b1;
            end else begin
                r_state <= S_RUN;
                r_exc   <= 1'b0;
                r_rdy   <= 1'b0;
            end
        end else begin
            case (r_state)
                S_RUN: begin
                    r_rem <= w_rem_next;
                    r_quo <= w_quo_next;
                    r_cnt <= r_cnt + CNT_ONE;
                    if (r_cnt == LAST_ITER) begin
                        r_state  <= S_DONE;
                        r_rdy    <= 1'b1;
                        r_result <= r_sign ? (~w_quo_next + ONE) : w_quo_next;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_rdy   <= 1'b0;
                    r_exc   <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign data_result    = r_result;
    assign data_exception = r_exc;
    assign data_resultRDY = r_rdy;

endmodule
